// File: rtl/rom_loader.sv
// rom_loader: one SPI READ (0x03) from flash streams rom_bytes into the ROM write port; CPU held in reset until done.
// Latency: byte written one clock after its last bit is sampled; done at E0 + clk_div*(2*(32+8*rom_bytes)-1) + 2.
// Backpressure: none, one-clock write strobes; optional running byte sum under ROM_LOADER_CHECKSUM_EN.
module rom_loader #(
   parameter int          rom_bytes    = 8192,
   parameter logic [23:0] flash_offset = 24'h000000,
   parameter int          clk_div      = 2
) (
   input  logic        clock,
   input  logic        reset,
   output logic        flash_csn,
   output logic        flash_sck,
   output logic        flash_mosi,
   input  logic        flash_miso,
   output logic [15:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        wr_en,
   output logic        done,
   output logic        cpu_reset,
   output logic [7:0]  checksum
);
   localparam int            dw        = (clk_div > 1) ? $clog2(clk_div) : 1;
   localparam logic [dw-1:0] div_max   = dw'(clk_div - 1);
   localparam logic [dw-1:0] div_one   = dw'(1);
   localparam logic [15:0]   last_addr = 16'(rom_bytes - 1);
   localparam logic [31:0]   cmd_word  = {8'h03, flash_offset};

   typedef enum logic [1:0] {s_idle, s_cmd, s_data, s_finish} state_t;

   state_t        state;
   logic [dw-1:0] div_cnt;
   logic [31:0]   cmd_sr;
   logic [7:0]    in_sr;
   logic [4:0]    bit_cnt;
   logic [15:0]   addr_cnt;
   logic          byte_rdy;
   logic          tick;

   assign tick = (div_cnt == div_max);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= s_idle;
         flash_csn  <= 1'b1;
         flash_sck  <= 1'b0;
         flash_mosi <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= 16'h0000;
         wr_data    <= 8'h00;
         done       <= 1'b0;
         cpu_reset  <= 1'b1;
         div_cnt    <= '0;
         cmd_sr     <= 32'h0;
         in_sr      <= 8'h00;
         bit_cnt    <= 5'd0;
         addr_cnt   <= 16'h0000;
         byte_rdy   <= 1'b0;
      end else begin
         wr_en    <= 1'b0;
         byte_rdy <= 1'b0;
         case (state)
            s_idle: begin
               flash_csn  <= 1'b0;
               flash_mosi <= cmd_word[31];
               cmd_sr     <= cmd_word;
               div_cnt    <= '0;
               bit_cnt    <= 5'd0;
               addr_cnt   <= 16'h0000;
               state      <= s_cmd;
            end
            s_cmd, s_data: begin
               div_cnt <= tick ? '0 : div_cnt + div_one;
               if (tick) begin
                  flash_sck <= ~flash_sck;
                  if (!flash_sck) begin
                     // rising SCK edge: sample MISO (data phase only)
                     if (state == s_data) begin
                        in_sr <= {in_sr[6:0], flash_miso};
                        if (bit_cnt[2:0] == 3'd7) begin
                           bit_cnt  <= 5'd0;
                           byte_rdy <= 1'b1;
                        end else begin
                           bit_cnt <= bit_cnt + 5'd1;
                        end
                     end
                  end else if (state == s_cmd) begin
                     cmd_sr     <= {cmd_sr[30:0], 1'b0};
                     flash_mosi <= cmd_sr[30];
                     bit_cnt    <= bit_cnt + 5'd1;
                     if (bit_cnt == 5'd31) begin
                        state      <= s_data;
                        flash_mosi <= 1'b0;
                        bit_cnt    <= 5'd0;
                     end
                  end
               end
               if (byte_rdy) begin
                  wr_en    <= 1'b1;
                  wr_addr  <= addr_cnt;
                  wr_data  <= in_sr;
                  addr_cnt <= addr_cnt + 16'd1;
                  if (addr_cnt == last_addr) state <= s_finish;
               end
            end
            default: begin
               flash_csn  <= 1'b1;
               flash_sck  <= 1'b0;
               flash_mosi <= 1'b0;
               done       <= 1'b1;
               cpu_reset  <= 1'b0;
            end
         endcase
      end
   end

`ifdef ROM_LOADER_CHECKSUM_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         checksum <= 8'h00;
      end else if (state == s_idle) begin
         checksum <= 8'h00;
      end else if (byte_rdy && state == s_data) begin
         checksum <= checksum + in_sr;
      end
   end
`else
   assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: two instances (16 bytes/div 2/offset 0, 4 bytes/div 1/offset 0x012345) with flash models.
module tb_rom_loader;
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic csn0, sck0, mosi0, we0, done0, cr0;
   logic miso0 = 1'b0;
   logic [15:0] wa0;
   logic [7:0]  wd0, ck0;
   logic csn1, sck1, mosi1, we1, done1, cr1;
   logic miso1 = 1'b0;
   logic [15:0] wa1;
   logic [7:0]  wd1, ck1;

   rom_loader #(.rom_bytes(16), .flash_offset(24'h000000), .clk_div(2)) u0 (
      .clock(clock), .reset(reset), .flash_csn(csn0), .flash_sck(sck0), .flash_mosi(mosi0),
      .flash_miso(miso0), .wr_addr(wa0), .wr_data(wd0), .wr_en(we0), .done(done0),
      .cpu_reset(cr0), .checksum(ck0));

   rom_loader #(.rom_bytes(4), .flash_offset(24'h012345), .clk_div(1)) u1 (
      .clock(clock), .reset(reset), .flash_csn(csn1), .flash_sck(sck1), .flash_mosi(mosi1),
      .flash_miso(miso1), .wr_addr(wa1), .wr_data(wd1), .wr_en(we1), .done(done1),
      .cpu_reset(cr1), .checksum(ck1));

   int total = 0;
   int passed = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Flash byte at address a is a[7:0]; address comes from the received command.
   function automatic logic model_bit(input logic [23:0] base, input int b);
      logic [23:0] a;
      a = base + 24'(b / 8);
      return a[7 - (b % 8)];
   endfunction

   int m0_n = 0, m1_n = 0;
   logic [31:0] m0_cmd = 32'h0, m1_cmd = 32'h0;

   always @(posedge sck0 or negedge csn0)
      if (!sck0) m0_n <= 0;
      else if (!csn0) begin
         if (m0_n < 32) m0_cmd <= {m0_cmd[30:0], mosi0};
         m0_n <= m0_n + 1;
      end
   always @(negedge sck0)
      if (m0_n >= 32) miso0 <= model_bit(m0_cmd[23:0], m0_n - 32);

   always @(posedge sck1 or negedge csn1)
      if (!sck1) m1_n <= 0;
      else if (!csn1) begin
         if (m1_n < 32) m1_cmd <= {m1_cmd[30:0], mosi1};
         m1_n <= m1_n + 1;
      end
   always @(negedge sck1)
      if (m1_n >= 32) miso1 <= model_bit(m1_cmd[23:0], m1_n - 32);

   // cycles since reset release; at the negedge after edge E0+n, cyc-1 == n
   int cyc = 0;
   always @(posedge clock)
      if (reset) cyc <= 0;
      else cyc <= cyc + 1;

   logic [15:0] wa_log [0:31];
   logic [7:0]  wd_log [0:31];
   int nw0, wide0, crviol0, done0_at, idle_bad;
   logic we0_prev;
   logic [7:0] ck0_done;
   always @(negedge clock)
      if (reset) begin
         nw0 <= 0; wide0 <= 0; crviol0 <= 0; done0_at <= -1; we0_prev <= 1'b0;
         if (csn0 !== 1'b1 || sck0 !== 1'b0 || we0 !== 1'b0 || csn1 !== 1'b1 || sck1 !== 1'b0 || we1 !== 1'b0)
            idle_bad <= idle_bad + 1;
      end else begin
         we0_prev <= we0;
         if (we0) begin
            if (nw0 < 32) begin
               wa_log[nw0] <= wa0;
               wd_log[nw0] <= wd0;
            end
            nw0 <= nw0 + 1;
         end
         if (we0 && we0_prev) wide0 <= wide0 + 1;
         if (!cr0 && !done0) crviol0 <= crviol0 + 1;
         if (done0 && done0_at < 0) begin
            done0_at <= cyc - 1;
            ck0_done <= ck0;
         end
      end

   int last_wr1, done1_at, last_sck1, first1;
   logic sck1_prev, csn1_at_done;
   logic [7:0] ck1_done;
   always @(negedge clock)
      if (reset) begin
         last_wr1 <= -1; done1_at <= -1; last_sck1 <= -1; first1 <= -1; sck1_prev <= 1'b0;
      end else begin
         sck1_prev <= sck1;
         if (sck1 !== sck1_prev) last_sck1 <= cyc - 1;
         if (we1) last_wr1 <= cyc - 1;
         if (we1 && first1 < 0) first1 <= int'(wd1);
         if (done1 && done1_at < 0) begin
            done1_at     <= cyc - 1;
            csn1_at_done <= csn1;
            ck1_done     <= ck1;
         end
      end

`ifndef ROM_LOADER_CHECKSUM_EN
   int cknz = 0;
   always @(negedge clock)
      if (ck0 !== 8'h00 || ck1 !== 8'h00) cknz <= cknz + 1;
`endif

   task automatic check_writes(input string tag);
      int errs;
      errs = 0;
      for (int i = 0; i < 16; i++)
         if (wa_log[i] !== 16'(i) || wd_log[i] !== 8'(i)) errs++;
      check({tag, "_count"}, nw0, 16);
      check({tag, "_seq"}, errs, 0);
      check({tag, "_width"}, wide0, 0);
      check({tag, "_cmd"}, m0_cmd, 32'h03000000);
      check({tag, "_bits"}, m0_n, 160);
      check({tag, "_done_at"}, done0_at, 640);
   endtask

   initial begin
      idle_bad = 0;
      reset = 1'b1;
      repeat (50) @(negedge clock);
      #1;
      check("idle_pins", idle_bad, 0);
      check("rst_csn", csn0, 1'b1);
      check("rst_sck", sck0, 1'b0);
      check("rst_mosi", mosi0, 1'b0);
      check("rst_wr_addr", wa0, 16'h0000);
      check("rst_wr_data", wd0, 8'h00);
      check("rst_done", done0, 1'b0);
      check("rst_cpu_reset", cr0, 1'b1);
      check("rst_checksum", ck0, 8'h00);

      // full load
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 3000 && !(done0 === 1'b1 && done1 === 1'b1); i++) @(negedge clock);
      repeat (10) @(negedge clock);
      #1;
      check("load_done", {31'd0, done0 & done1}, 1);
      check_writes("load");
      check("cpu_reset_hold", crviol0, 0);
      check("cpu_reset_release", cr0, 1'b0);
      check("done_csn", csn0, 1'b1);
      check("off_cmd", m1_cmd, 32'h03012345);
      check("off_first_byte", first1, 32'h45);
      check("cyc_last_wr", last_wr1, 128);
      check("cyc_done", done1_at, 129);
      check("cyc_csn", csn1_at_done, 1'b1);
      check("cyc_last_sck", last_sck1, 128);
`ifdef ROM_LOADER_CHECKSUM_EN
      check("checksum0", ck0_done, 8'h78);
      check("checksum1", ck1_done, 8'h1a);
`else
      check("checksum_zero", cknz, 0);
`endif

      // reset in the middle of a load
      reset = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 2000 && nw0 < 3; i++) @(negedge clock);
      #1;
      check("mid_third_write", nw0, 3);
      check("mid_pre_addr", wa0, 16'h0002);
      reset = 1'b1;
      #1;
      check("mid_csn", csn0, 1'b1);
      check("mid_sck", sck0, 1'b0);
      check("mid_cpu_reset", cr0, 1'b1);
      check("mid_wr_addr", wa0, 16'h0000);
      check("mid_done", done0, 1'b0);
      repeat (5) @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 3000 && done0 !== 1'b1; i++) @(negedge clock);
      repeat (3) @(negedge clock);
      #1;
      check("reload_done", {31'd0, done0}, 1);
      check_writes("reload");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
